// File: rtl/adc_sample_frontend.sv
// Frame counter plus MCP3002-style SPI reader; publishes one 10-bit sample
// and an EMA DC-offset estimate at every frame start.
`timescale 1ns/1ps
module adc_sample_frontend #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       miso,
  input  logic       channel,
  input  logic       freeze_offset,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic [9:0] counter,
  output logic [9:0] sampleVoltage,
  output logic [9:0] offset,
  output logic       sample_valid
);

  localparam int unsigned DIV_W = 5;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [3:0]       bit_idx, bit_next;
  logic [15:0]      tx, tx_next;
  logic [9:0]       rx, rx_next;
  logic             sclk_next, cs_n_next, mosi_next;
  logic             div_last;

  logic [9:0]       pending;
  logic             ready;
  logic [15:0]      acc;
  logic             publish;

  assign div_last = (div_cnt == DIV_LAST);
  assign publish  = (counter == 10'd1023) && ready;
  assign offset   = acc[15:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      tx      <= '0;
      rx      <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_idx <= bit_next;
      tx      <= tx_next;
      rx      <= rx_next;
      sclk    <= sclk_next;
      cs_n    <= cs_n_next;
      mosi    <= mosi_next;
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_idx;
    tx_next    = tx;
    rx_next    = rx;
    sclk_next  = sclk;
    cs_n_next  = cs_n;
    mosi_next  = mosi;
    case (state)
      IDLE: begin
        if (counter == 10'd8) begin
          state_next = START;
          tx_next    = {1'b1, 1'b1, channel, 1'b1, 12'b0};
          cs_n_next  = 1'b0;
          sclk_next  = 1'b0;
          mosi_next  = 1'b1;
          bit_next   = 4'd15;
          div_next   = '0;
          rx_next    = '0;
        end
      end
      START: begin
        if (div_last) begin
          state_next = SHIFT;
          div_next   = '0;
          sclk_next  = 1'b1;
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_next = div_cnt + 1'b1;
        end else begin
          div_next = '0;
          if (sclk) begin
            sclk_next = 1'b0;
            tx_next   = {tx[14:0], 1'b0};
            mosi_next = tx[14];
            // Only bits 10..1 are ever used; the last 10 shifts before bit 0
            // leave exactly D9..D0 in this 10-bit register.
            if (bit_idx != 4'd0)
              rx_next = {rx[8:0], miso};
          end else if (bit_idx == 4'd0) begin
            state_next = DONE;
          end else begin
            sclk_next = 1'b1;
            bit_next  = bit_idx - 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        cs_n_next  = 1'b1;
        sclk_next  = 1'b0;
        mosi_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter       <= '0;
      sampleVoltage <= 10'h200;
      acc           <= 16'h8000;
      pending       <= 10'h200;
      ready         <= 1'b0;
      sample_valid  <= 1'b0;
    end else begin
      counter      <= counter + 1'b1;
      sample_valid <= publish;
      if (publish) begin
        sampleVoltage <= pending;
        ready         <= 1'b0;
        // Intermediate sum may wrap 16 bits; the final value is always in range.
        if (!freeze_offset)
          acc <= acc + {6'b0, pending} - {6'b0, acc[15:6]};
      end else if (state == DONE) begin
        pending <= rx;
        ready   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_frontend.sv
// Drives adc_sample_frontend with an SPI ADC model and checks framing,
// capture and offset tracking against an arithmetic reference model.
`timescale 1ns/1ps
module tb_adc_sample_frontend;

  localparam int unsigned CLK_DIV  = 8;
  localparam int unsigned CS_RISE  = 9 + 33 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       miso = 1'b0;
  logic       channel = 1'b0;
  logic       freeze_offset = 1'b0;
  logic       sclk, cs_n, mosi;
  logic [9:0] counter, sample_voltage, offset;
  logic       sample_valid;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int          model_acc;
  int          model_sv;
  logic [9:0]  cur_data;
  logic [15:0] exp_cmd;

  // ADC model / bus monitor state
  logic [15:0] adc_word = '0;
  logic [15:0] cmd = '0;
  int          k = 0;
  int          pulses = 0, bad_high = 0, bad_low = 0, run = 0;
  int          bad_idle = 0, bad_mosi = 0;
  logic        prev_cs_low = 1'b0, prev_sclk = 1'b0, prev_mosi = 1'b0;

  adc_sample_frontend #(.CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .miso          (miso),
    .channel       (channel),
    .freeze_offset (freeze_offset),
    .sclk          (sclk),
    .cs_n          (cs_n),
    .mosi          (mosi),
    .counter       (counter),
    .sampleVoltage (sample_voltage),
    .offset        (offset),
    .sample_valid  (sample_valid)
  );

  always #5 clk = ~clk;

  // ADC: capture command on sclk rise, present next response bit for the high phase
  always @(posedge sclk or negedge cs_n) begin
    if (!sclk) begin
      k    = 0;
      cmd  = '0;
      miso = 1'b0;
    end else begin
      cmd = {cmd[14:0], mosi};
      if (k < 16) miso = adc_word[15 - k];
      k++;
    end
  end

  always @(negedge clk) begin
    if (cs_n && sclk) bad_idle++;
    if (mosi !== prev_mosi && sclk) bad_mosi++;
    if (!cs_n) begin
      if (!prev_cs_low) begin
        run = 1; pulses = 0; bad_high = 0; bad_low = 0;
      end else if (sclk == prev_sclk) begin
        run++;
      end else begin
        if (prev_sclk) begin
          if (run != int'(CLK_DIV)) bad_high++;
        end else begin
          if (run != int'(CLK_DIV)) bad_low++;
          pulses++;
        end
        run = 1;
      end
    end
    prev_cs_low = !cs_n;
    prev_sclk   = sclk;
    prev_mosi   = mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input logic level, input string tag);
    int n = 0;
    while (cs_n !== level && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(cs_n === level), 32'd1);
  endtask

  task automatic wait_count(input logic [9:0] target, input string tag);
    int n = 0;
    while (counter !== target && n < 2100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(counter === target), 32'd1);
  endtask

  task automatic prep(input logic [9:0] data, input logic ch, input logic frz);
    cur_data      = data;
    channel       = ch;
    freeze_offset = frz;
    exp_cmd       = ch ? 16'hF000 : 16'hD000;
    adc_word      = {4'($urandom), 1'b0, data, 1'($urandom)};
  endtask

  task automatic run_conv();
    wait_cs(1'b0, "cs_fall_timeout");
    check("cs_fall_counter", counter, 32'd9);
    wait_cs(1'b1, "cs_rise_timeout");
    check("cs_rise_counter", counter, CS_RISE);
    check("mosi_cmd", cmd, exp_cmd);
    check("sclk_pulses", pulses, 32'd16);
    check("sclk_high_width", bad_high, 32'd0);
    check("sclk_low_width", bad_low, 32'd0);
    wait_count(10'd1023, "frame_end_timeout");
    check("valid_before_publish", sample_valid, 32'd0);
    check("sample_hold", sample_voltage, model_sv);
    check("offset_hold", offset, model_acc / 64);
    model_sv = cur_data;
    if (!freeze_offset) model_acc = model_acc + cur_data - model_acc / 64;
    @(posedge clk); #1;
    check("publish_counter", counter, 32'd0);
    check("publish_valid", sample_valid, 32'd1);
    check("publish_sample", sample_voltage, model_sv);
    check("publish_offset", offset, model_acc / 64);
    @(posedge clk); #1;
    check("valid_one_cycle", sample_valid, 32'd0);
  endtask

  initial begin
    model_acc = 32'h8000;
    model_sv  = 32'h200;
    prep(10'h300, 1'b1, 1'b0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", cs_n, 32'd1);
    check("rst_sclk", sclk, 32'd0);
    check("rst_mosi", mosi, 32'd0);
    check("rst_counter", counter, 32'd0);
    check("rst_sample", sample_voltage, 32'h200);
    check("rst_offset", offset, 32'h200);
    check("rst_valid", sample_valid, 32'd0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("cnt8_counter", counter, 32'd8);
    check("cnt8_cs_n", cs_n, 32'd1);
    @(posedge clk); #1;
    check("cnt9_cs_n", cs_n, 32'd0);

    // constant 0x300: first two EMA steps
    run_conv();
    check("ema_step1", offset, 32'h204);
    prep(10'h300, 1'b0, 1'b0);
    run_conv();
    check("ema_step2", offset, 32'h207);

    prep(10'h2AB, 1'b0, 1'b0); run_conv();
    prep(10'h000, 1'b1, 1'b0); run_conv();
    prep(10'h3FF, 1'b0, 1'b0); run_conv();
    for (int i = 0; i < 6; i++) begin
      prep(10'($urandom), 1'($urandom), 1'b0);
      run_conv();
    end

    // frozen offset while the input steps
    prep(10'h100, 1'b1, 1'b1); run_conv();
    prep(10'h3FF, 1'b0, 1'b1); run_conv();
    prep(10'($urandom), 1'b1, 1'b1); run_conv();

    // reset in the middle of a transfer
    prep(10'h155, 1'b1, 1'b0);
    wait_count(10'd100, "mid_count_timeout");
    check("mid_cs_low", cs_n, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_cs_n", cs_n, 32'd1);
    check("mid_rst_sclk", sclk, 32'd0);
    check("mid_rst_counter", counter, 32'd0);
    check("mid_rst_sample", sample_voltage, 32'h200);
    check("mid_rst_offset", offset, 32'h200);
    model_acc = 32'h8000;
    model_sv  = 32'h200;
    repeat (2) @(negedge clk);
    prep(10'h300, 1'b1, 1'b0);
    reset = 1'b0;
    run_conv();
    check("post_rst_sample", sample_voltage, 32'h300);
    check("post_rst_ema", offset, 32'h204);

    for (int i = 0; i < 6; i++) begin
      prep(10'($urandom), 1'($urandom), 1'($urandom));
      run_conv();
    end

    check("sclk_idle_toggle", bad_idle, 32'd0);
    check("mosi_change_high", bad_mosi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
